stream_downsize: RTL and testbench
==================================

Name: stream_downsize

Overview:
Width down-converter for the valid/ready stream. It accepts one wide beat of T_DATA_RATIO lanes plus a per-lane keep mask and serializes the kept lanes onto a narrow T_DATA_WIDTH output, lane 0 first. It is the counterpart of the upsizer: it sits where packed multi-lane words return to a narrow stream and restores packet boundaries through m_last_o.

Parameters:
T_DATA_WIDTH, 4, width of one lane and of the output word
T_DATA_RATIO, 2, number of lanes per input beat (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
s_data_i  input  T_DATA_WIDTH x [T_DATA_RATIO]  unpacked lane array, index 0 sent first
s_keep_i  input  T_DATA_RATIO  lane i valid when bit i = 1
s_last_i  input  1  beat ends a packet
s_valid_i  input  1  input beat valid
s_ready_o  output  1  block can accept a beat
m_data_o  output  T_DATA_WIDTH  current narrow word
m_last_o  output  1  final word of packet
m_valid_o  output  1  output word valid
m_ready_i  input  1  downstream accepts word

Behaviour:
- Reset: rst is sampled on the clk edge only. While rst=1, s_ready_o=0, m_valid_o=0 and m_last_o=0. On the first cycle after reset, state is IDLE and s_ready_o=1. A reset during SEND discards the held beat with no partial output afterwards.
- Registers:
  - data_q: lane array.
  - rem_q: T_DATA_RATIO-bit mask of lanes still to send.
  - last_q: captured s_last_i.
- States:
  - IDLE: rem_q == 0.
  - SEND: rem_q != 0.
- Capture: an input handshake occurs when s_valid_i & s_ready_o. It loads data_q <= s_data_i, rem_q <= s_keep_i and last_q <= s_last_i.
- Latency: a beat accepted at edge N presents its first kept lane at cycle N+1.
- Current lane: the lowest set bit of rem_q.
  - m_data_o = data_q[current lane].
  - m_valid_o = (rem_q != 0).
- Output handshake (m_valid_o & m_ready_i): clears the current lane bit in rem_q. The next kept lane appears on the next cycle. Lanes with keep=0 are skipped and cost no cycles.
- Final word: final_lane = rem_q has exactly one bit set. m_last_o = last_q & final_lane & m_valid_o.
- Stall: while m_valid_o & ~m_ready_i, m_data_o and m_last_o are held stable. Downstream stalls never corrupt or drop data.
- s_ready_o (base build): 1 only in IDLE and not in reset. A beat with n kept lanes therefore occupies n+1 cycles at full downstream rate, giving one bubble per beat.
- All-zero keep: the beat is accepted and consumed in one cycle with no output, and the block stays in IDLE. Its s_last_i is discarded. Upstream must not send all-zero-keep last beats.
- Keep holes (e.g. 4'b1010): only the set lanes are sent, in ascending index order.
- Protocol rule: m_valid_o never drops without a handshake once asserted.
- No combinational path from m_ready_i to s_ready_o in the base build.

Optional Feature:
STREAM_DOWNSIZE_PREFETCH_EN.
- Defined: s_ready_o = ~rst & (rem_q == 0 | (final_lane & m_valid_o & m_ready_i)). A new beat loads in the same cycle the last lane of the current beat handshakes. This removes the bubble, so n kept lanes take exactly n cycles back-to-back. It adds a combinational m_ready_i -> s_ready_o path.
- Undefined: base behaviour, s_ready_o depends only on the registered state.

Test Plan:
- Reset: hold rst=1 for 3 cycles with s_valid_i=1 -> s_ready_o=0, m_valid_o=0. Release -> s_ready_o=1 next cycle.
- Full beat: RATIO=2, data {lane0=4'hA, lane1=4'h5}, keep=2'b11, last=1, m_ready_i=1 -> outputs 4'hA (last=0) then 4'h5 (last=1) on cycles N+1 and N+2. s_ready_o returns to 1 at N+3 base, or at N+2 with PREFETCH_EN.
- Sparse keep: RATIO=4, data {1,2,3,4}, keep=4'b1010, last=1 -> outputs 2 then 4 with last on 4. Lanes 0 and 2 never appear.
- Backpressure: during the full-beat case, hold m_ready_i=0 for 5 cycles on the first word -> m_data_o=4'hA stable for 5 cycles, then 4'h5. No loss or duplicate.
- Throughput: 8 consecutive full beats with last only on beat 8 and m_ready_i=1 -> 16 words in order, exactly one m_last_o. Takes 24 cycles base, 16 cycles with PREFETCH_EN.
- Edge cases: keep=0 beat is consumed with no output. A reset asserted while the second lane is pending -> no further m_valid_o, and the next packet starts clean at lane 0.

Source files
------------

// File: rtl/stream_downsize.sv
// stream_downsize: serializes kept lanes of a wide beat onto a narrow stream; define STREAM_DOWNSIZE_PREFETCH_EN for bubble-free reload
module stream_downsize #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);
  localparam int iw = T_DATA_RATIO > 1 ? $clog2(T_DATA_RATIO) : 1;
  logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] rem_q, rem_rest;
  logic                    last_q, final_lane, m_fire, s_fire;
  logic [iw-1:0]           lane;
  assign rem_rest   = rem_q & (rem_q - T_DATA_RATIO'(1));
  assign final_lane = (rem_q != '0) && (rem_rest == '0);
  assign m_valid_o  = ~rst & (rem_q != '0);
  assign m_fire     = m_valid_o & m_ready_i;
  assign s_fire     = s_valid_i & s_ready_o;
  assign m_data_o   = data_q[lane];
  assign m_last_o   = last_q & final_lane & m_valid_o;
`ifdef STREAM_DOWNSIZE_PREFETCH_EN
  assign s_ready_o  = ~rst & ((rem_q == '0) | (final_lane & m_fire));
`else
  assign s_ready_o  = ~rst & (rem_q == '0);
`endif
  // descending scan leaves the lowest pending lane selected
  always_comb begin
    lane = '0;
    for (int i = T_DATA_RATIO - 1; i >= 0; i--) if (rem_q[i]) lane = iw'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      last_q <= 1'b0;
    end else if (s_fire) begin
      data_q <= s_data_i;
      rem_q  <= s_keep_i;
      last_q <= s_last_i;
    end else if (m_fire) begin
      rem_q  <= rem_rest;
    end
  end
endmodule

// File: tb/tb_stream_downsize.sv
// tb_stream_downsize: directed checks of the lane serializer at ratios 2 and 4
module tb_stream_downsize;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sd2 [2];
  logic [1:0] sk2;
  logic       sl2, sv2, sr2, ml2, mv2, mr2;
  logic [3:0] md2;
  logic [3:0] sd4 [4];
  logic [3:0] sk4;
  logic       sl4, sv4, sr4, ml4, mv4, mr4;
  logic [3:0] md4;
  int checks = 0, errors = 0;
`ifdef STREAM_DOWNSIZE_PREFETCH_EN
  localparam bit pf = 1'b1;
`else
  localparam bit pf = 1'b0;
`endif
  always #5 clk = ~clk;

  stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) u2 (
    .clk(clk), .rst(rst), .s_data_i(sd2), .s_keep_i(sk2), .s_last_i(sl2), .s_valid_i(sv2),
    .s_ready_o(sr2), .m_data_o(md2), .m_last_o(ml2), .m_valid_o(mv2), .m_ready_i(mr2));
  stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(4)) u4 (
    .clk(clk), .rst(rst), .s_data_i(sd4), .s_keep_i(sk4), .s_last_i(sl4), .s_valid_i(sv4),
    .s_ready_o(sr4), .m_data_o(md4), .m_last_o(ml4), .m_valid_o(mv4), .m_ready_i(mr4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat, words, lasts, first, lastw, cyc;
    sd2[0] = 4'h1; sd2[1] = 4'h2; sk2 = 2'b11; sl2 = 1'b1; sv2 = 1'b1; mr2 = 1'b1;
    for (int i = 0; i < 4; i++) sd4[i] = 4'h0;
    sk4 = 4'h0; sl4 = 1'b0; sv4 = 1'b0; mr4 = 1'b1;
    repeat (3) begin
      tick;
      chk("rst_sready", sr2, 0);
      chk("rst_mvalid", mv2, 0);
      chk("rst_mlast", ml2, 0);
    end
    rst = 1'b0; sv2 = 1'b0;
    #1 chk("rel_mvalid", mv2, 0);
    tick;
    chk("rel_sready", sr2, 1);
    // full beat at full downstream rate
    sd2[0] = 4'hA; sd2[1] = 4'h5; sk2 = 2'b11; sl2 = 1'b1; sv2 = 1'b1;
    #1 chk("full_sready_in", sr2, 1);
    tick; sv2 = 1'b0;
    #1 chk("full_d0", md2, 4'hA); chk("full_l0", ml2, 0); chk("full_v0", mv2, 1); chk("full_sr0", sr2, 0);
    tick;
    #1 chk("full_d1", md2, 4'h5); chk("full_l1", ml2, 1); chk("full_v1", mv2, 1); chk("full_sr1", sr2, pf);
    tick;
    #1 chk("full_v2", mv2, 0); chk("full_sr2", sr2, 1);
    // backpressure on the first word
    sv2 = 1'b1; mr2 = 1'b0;
    tick; sv2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_hold_d", md2, 4'hA); chk("bp_hold_v", mv2, 1); chk("bp_hold_l", ml2, 0);
      tick;
    end
    mr2 = 1'b1;
    #1 chk("bp_d0", md2, 4'hA);
    tick;
    #1 chk("bp_d1", md2, 4'h5); chk("bp_l1", ml2, 1);
    tick;
    #1 chk("bp_end_v", mv2, 0);
    // sparse keep at ratio 4
    sd4[0] = 4'h1; sd4[1] = 4'h2; sd4[2] = 4'h3; sd4[3] = 4'h4;
    sk4 = 4'b1010; sl4 = 1'b1; sv4 = 1'b1;
    tick; sv4 = 1'b0;
    #1 chk("sp_d0", md4, 2); chk("sp_l0", ml4, 0); chk("sp_v0", mv4, 1);
    tick;
    #1 chk("sp_d1", md4, 4); chk("sp_l1", ml4, 1); chk("sp_v1", mv4, 1);
    tick;
    #1 chk("sp_v2", mv4, 0); chk("sp_sr2", sr4, 1);
    // all-zero keep beat
    sk2 = 2'b00; sl2 = 1'b1; sv2 = 1'b1;
    #1 chk("kz_sr_in", sr2, 1);
    tick; sv2 = 1'b0;
    #1 chk("kz_v", mv2, 0); chk("kz_l", ml2, 0); chk("kz_sr", sr2, 1);
    tick;
    #1 chk("kz_v_next", mv2, 0);
    // eight back-to-back beats, last only on the eighth
    beat = 0; words = 0; lasts = 0; first = -1; lastw = -1; cyc = 0;
    while (words < 16 && cyc < 100) begin
      sv2 = (beat < 8); sk2 = 2'b11; sl2 = (beat == 7);
      sd2[0] = 4'(2 * beat); sd2[1] = 4'(2 * beat + 1);
      #1;
      if (sv2 && sr2) beat++;
      if (mv2 && mr2) begin
        chk("tp_data", md2, words);
        chk("tp_last", ml2, words == 15);
        if (ml2) lasts++;
        if (first < 0) first = cyc;
        lastw = cyc;
        words++;
      end
      tick;
      cyc++;
    end
    sv2 = 1'b0; sl2 = 1'b0;
    chk("tp_words", words, 16);
    chk("tp_lasts", lasts, 1);
    chk("tp_span", lastw - first + 1, pf ? 16 : 23);
    #1 chk("tp_idle", mv2, 0);
    // reset while the second lane is pending
    sd2[0] = 4'h3; sd2[1] = 4'h7; sk2 = 2'b11; sl2 = 1'b1; sv2 = 1'b1;
    tick; sv2 = 1'b0;
    #1 chk("rs_d0", md2, 3);
    tick;
    #1 chk("rs_d1", md2, 7); chk("rs_v1", mv2, 1);
    rst = 1'b1;
    #1 chk("rs_v_in_rst", mv2, 0); chk("rs_sr_in_rst", sr2, 0);
    tick; rst = 1'b0;
    #1 chk("rs_v_after", mv2, 0); chk("rs_sr_after", sr2, 1);
    tick;
    #1 chk("rs_v_idle", mv2, 0);
    sd2[0] = 4'h9; sd2[1] = 4'h6; sv2 = 1'b1;
    tick; sv2 = 1'b0;
    #1 chk("rs_n0", md2, 9); chk("rs_nl0", ml2, 0);
    tick;
    #1 chk("rs_n1", md2, 6); chk("rs_nl1", ml2, 1);
    tick;
    #1 chk("rs_end_v", mv2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
